// File: rtl/spi_slave_fl.sv
// spi_slave_fl: device end of a single-lane SPI flash link; decodes command, 24-bit address, dummy and data fields.
// Define SPI_SLAVE_FL_READID_EN to build in READ ID (0x9F) answered from FLASH_ID.
module spi_slave_fl #(
   parameter bit          CPOL         = 1'b1,
   parameter bit          CPHA         = 1'b1,
   parameter int unsigned DUMMY_CYCLES = 8,
   parameter logic [23:0] FLASH_ID     = 24'h20BA19
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ss_i,
   input  logic        sclk_i,
   input  logic        mosi_dq0_i,
   output logic        miso_dq1_o,
   output logic        miso_oe_o,
   output logic [7:0]  cmd_o,
   output logic [23:0] addr_o,
   output logic        cmd_valid_o,
   output logic        cmd_unknown_o,
   output logic [7:0]  wr_data_o,
   output logic        wr_valid_o,
   output logic        rd_req_o,
   input  logic [7:0]  rd_data_i,
   output logic        frame_done_o,
   output logic        busy_o
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE} state_e;
   state_e      state_q, state_d;
   logic [2:0]  sclk_q, ss_q;
   logic [1:0]  mosi_q;
   logic        arm_q;
   logic [7:0]  cnt_q, cnt_d, cmd_q, cmd_d, osr_q, osr_d, wd_q, wd_d, out_byte;
   logic [22:0] sr_q, sr_d;
   logic [23:0] addr_q, addr_d;
   logic [2:0]  ocnt_q, ocnt_d;
   logic        miso_q, miso_d, cv_q, cv_d, cu_q, cu_d, wv_q, wv_d, rr_q, rr_d, fd_q, fd_d;
   logic        rise, fall, sample, shift, mosi, ss_rise, ss_fall, is_id;

   assign rise    = sclk_q[1] & ~sclk_q[2];
   assign fall    = ~sclk_q[1] & sclk_q[2];
   assign sample  = (CPOL ^ CPHA) ? fall : rise;
   assign shift   = (CPOL ^ CPHA) ? rise : fall;
   assign mosi    = mosi_q[1];
   assign ss_rise = ss_q[1] & ~ss_q[2];
   // A frame only starts once ss has been seen high after reset, so a frame cut by reset is skipped.
   assign ss_fall = arm_q & ~ss_q[1] & ss_q[2];

`ifdef SPI_SLAVE_FL_READID_EN
   localparam bit ID_EN = 1'b1;
   logic [1:0] id_q, id_d;
   assign is_id    = cmd_q == 8'h9F;
   assign out_byte = !is_id ? rd_data_i : id_q == 2'd0 ? FLASH_ID[23:16] : id_q == 2'd1 ? FLASH_ID[15:8] : FLASH_ID[7:0];
   always_comb id_d = state_q != DOUT ? 2'd0 : !(shift && ocnt_q == 3'd0) ? id_q : id_q == 2'd2 ? 2'd0 : id_q + 2'd1;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) id_q <= 2'd0;
      else id_q <= id_d;
`else
   localparam bit ID_EN = 1'b0;
   logic unused_flash_id;
   assign unused_flash_id = ^FLASH_ID;
   assign is_id    = 1'b0;
   assign out_byte = rd_data_i;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = sample ? cnt_q + 8'd1 : cnt_q;
      sr_d    = sample ? {sr_q[21:0], mosi} : sr_q;
      ocnt_d  = state_q == DOUT ? ocnt_q + {2'b0, shift} : 3'd0;
      osr_d   = osr_q;
      miso_d  = miso_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      cv_d    = 1'b0;
      cu_d    = 1'b0;
      wv_d    = 1'b0;
      rr_d    = 1'b0;
      fd_d    = 1'b0;
      if (ss_rise) begin
         state_d = IDLE;
         fd_d    = arm_q;
      end else begin
         case (state_q)
            IDLE: if (ss_fall) begin
               state_d = CMD;
               cnt_d   = 8'd0;
            end
            CMD: if (sample && cnt_q == 8'd7) begin
               cmd_d = sr_d[7:0];
               cnt_d = 8'd0;
               cv_d  = 1'b1;
               if (sr_d[7:0] inside {8'h03, 8'h0B, 8'h02}) begin
                  state_d = ADDR;
                  cv_d    = 1'b0;
               end else if (ID_EN && sr_d[7:0] == 8'h9F) state_d = DOUT;
               else begin
                  state_d = IGNORE;
                  cu_d    = !(sr_d[7:0] inside {8'h06, 8'h04, 8'h66, 8'h99});
               end
            end
            ADDR: if (sample && cnt_q == 8'd23) begin
               addr_d  = {sr_q, mosi};
               cv_d    = 1'b1;
               cnt_d   = 8'd0;
               state_d = cmd_q == 8'h02 ? DIN : (cmd_q == 8'h0B && DUMMY_CYCLES != 0) ? DUMMY : DOUT;
               rr_d    = state_d == DOUT;
            end
            DUMMY: if (sample && cnt_q == 8'(DUMMY_CYCLES - 1)) begin
               state_d = DOUT;
               rr_d    = 1'b1;
            end
            // First shift of a byte loads it; the bit-6 shift prefetches the next one.
            DOUT: if (shift) begin
               miso_d = ocnt_q == 3'd0 ? out_byte[7] : osr_q[7];
               osr_d  = ocnt_q == 3'd0 ? {out_byte[6:0], 1'b0} : {osr_q[6:0], 1'b0};
               rr_d   = ocnt_q == 3'd1 && !is_id;
            end
            DIN: if (sample && cnt_q[2:0] == 3'd7) begin
               wd_d = sr_d[7:0];
               wv_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_q  <= {3{CPOL}};
         ss_q    <= 3'b000;
         mosi_q  <= 2'b00;
         arm_q   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         sr_q    <= 23'd0;
         ocnt_q  <= 3'd0;
         osr_q   <= 8'd0;
         miso_q  <= 1'b0;
         cmd_q   <= 8'd0;
         addr_q  <= 24'd0;
         wd_q    <= 8'd0;
         cv_q    <= 1'b0;
         cu_q    <= 1'b0;
         wv_q    <= 1'b0;
         rr_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         sclk_q  <= {sclk_q[1:0], sclk_i};
         ss_q    <= {ss_q[1:0], ss_i};
         mosi_q  <= {mosi_q[0], mosi_dq0_i};
         arm_q   <= arm_q | ss_q[1];
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         ocnt_q  <= ocnt_d;
         osr_q   <= osr_d;
         miso_q  <= miso_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         cv_q    <= cv_d;
         cu_q    <= cu_d;
         wv_q    <= wv_d;
         rr_q    <= rr_d;
         fd_q    <= fd_d;
      end
   end

   assign miso_dq1_o    = miso_q;
   assign miso_oe_o     = state_q == DOUT && !ss_q[1];
   assign cmd_o         = cmd_q;
   assign addr_o        = addr_q;
   assign cmd_valid_o   = cv_q;
   assign cmd_unknown_o = cu_q;
   assign wr_data_o     = wd_q;
   assign wr_valid_o    = wv_q;
   assign rd_req_o      = rr_q;
   assign frame_done_o  = fd_q;
   assign busy_o        = state_q != IDLE;
endmodule

// File: tb/tb_spi_slave_fl.sv
// tb_spi_slave_fl: mode-3 SPI master driving directed and random flash frames into spi_slave_fl,
// checked against a frame-level model of the flash responder.
`timescale 1ns/1ps
module tb_spi_slave_fl;
   localparam int H = 8;
   localparam int DUMMY = 8;
   localparam logic [7:0] IGN [4] = '{8'h06, 8'h04, 8'h66, 8'h99};
`ifdef SPI_SLAVE_FL_READID_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n, ss, sclk, mosi;
   logic miso, miso_oe, cmd_valid, cmd_unknown, wr_valid, rd_req, frame_done, busy;
   logic [7:0] cmd, wr_data, rd_data;
   logic [23:0] addr;
   logic [7:0] rd_mem [256] = '{default: 8'h00};
   logic [7:0] wr_q [$];
   logic [7:0] last_cmd = 8'h00;
   logic [23:0] last_addr = 24'h0;
   logic last_unk = 1'b0;
   int checks = 0, errors = 0, cv_n = 0, fd_n = 0, rr_n = 0, oe_n = 0;

   spi_slave_fl dut (
      .clk_i(clk), .rst_ni(rst_n), .ss_i(ss), .sclk_i(sclk), .mosi_dq0_i(mosi),
      .miso_dq1_o(miso), .miso_oe_o(miso_oe), .cmd_o(cmd), .addr_o(addr),
      .cmd_valid_o(cmd_valid), .cmd_unknown_o(cmd_unknown), .wr_data_o(wr_data),
      .wr_valid_o(wr_valid), .rd_req_o(rd_req), .rd_data_i(rd_data),
      .frame_done_o(frame_done), .busy_o(busy)
   );

   initial forever #5 clk = ~clk;

   // Controller: answers each rd_req with the next byte of rd_mem one clk later.
   initial begin
      rd_data = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (rd_req === 1'b1) begin
            rd_data = rd_mem[rr_n % 256];
            rr_n++;
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (cmd_valid === 1'b1) begin
         cv_n++;
         last_cmd = cmd;
         last_addr = addr;
         last_unk = cmd_unknown;
      end
      if (wr_valid === 1'b1) wr_q.push_back(wr_data);
      if (frame_done === 1'b1) fd_n++;
      if (miso_oe === 1'b1) oe_n++;
   end

   function automatic logic exp_unknown(input logic [7:0] op);
      return !(op inside {8'h03, 8'h0B, 8'h02, 8'h06, 8'h04, 8'h66, 8'h99}) && !(ID_EN && op == 8'h9F);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic tx, output logic rx);
      sclk = 1'b0; mosi = tx; tick(H);
      rx = miso; sclk = 1'b1; tick(H);
   endtask

   task automatic byte_x(input logic [7:0] tx, output logic [7:0] rx);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_x(tx[i], b);
         rx[i] = b;
      end
   endtask

   task automatic ss_lo();
      ss = 1'b0; tick(H);
   endtask

   task automatic ss_hi();
      tick(H); ss = 1'b1; tick(H);
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
      logic [7:0] rx;
      byte_x(op, rx); byte_x(a[23:16], rx); byte_x(a[15:8], rx); byte_x(a[7:0], rx);
   endtask

   task automatic frame_end(input int cv0, input int fd0, input logic [7:0] op, input logic [23:0] a);
      chk("cmd_valid_count", 32'(cv_n - cv0), 1);
      chk("cmd", last_cmd, op);
      chk("addr", last_addr, a);
      chk("cmd_unknown", last_unk, 0);
      chk("frame_done_count", 32'(fd_n - fd0), 1);
      chk("busy_after_ss", busy, 0);
      chk("oe_after_ss", miso_oe, 0);
   endtask

   task automatic read_frame(input logic [7:0] op, input logic [23:0] a, input logic [31:0] data, input int n);
      int cv0, fd0, rr0;
      logic [7:0] rx;
      logic b;
      cv0 = cv_n; fd0 = fd_n; rr0 = rr_n;
      for (int k = 0; k < n; k++) rd_mem[(rr0 + k) % 256] = data[31 - 8*k -: 8];
      ss_lo();
      send_hdr(op, a);
      if (op == 8'h0B) begin
         for (int k = 0; k < DUMMY - 1; k++) bit_x(1'b0, b);
         chk("oe_before_last_dummy", miso_oe, 0);
         bit_x(1'b0, b);
         chk("oe_after_last_dummy", miso_oe, 1);
      end
      for (int k = 0; k < n; k++) begin
         byte_x(8'h00, rx);
         chk("read_byte", rx, data[31 - 8*k -: 8]);
      end
      ss_hi();
      chk("rd_req_count", 32'(rr_n - rr0), 32'(1 + n));
      frame_end(cv0, fd0, op, a);
   endtask

   task automatic prog_frame(input logic [23:0] a, input logic [31:0] data, input int n, input int part);
      int cv0, fd0, wr0;
      logic [7:0] rx;
      logic b;
      cv0 = cv_n; fd0 = fd_n; wr0 = wr_q.size();
      ss_lo();
      send_hdr(8'h02, a);
      for (int k = 0; k < n; k++) byte_x(data[31 - 8*k -: 8], rx);
      for (int k = 0; k < part; k++) bit_x(1'($urandom), b);
      ss_hi();
      chk("wr_valid_count", 32'(wr_q.size() - wr0), 32'(n));
      for (int k = 0; k < n && wr0 + k < wr_q.size(); k++) chk("wr_byte", wr_q[wr0 + k], data[31 - 8*k -: 8]);
      frame_end(cv0, fd0, 8'h02, a);
   endtask

   task automatic op_frame(input logic [7:0] op, input int nbytes, output logic [31:0] rxs);
      int cv0, fd0, oe0;
      logic [7:0] rx;
      logic [23:0] a0;
      cv0 = cv_n; fd0 = fd_n; oe0 = oe_n; a0 = last_addr; rxs = 32'h0;
      ss_lo();
      byte_x(op, rx);
      for (int k = 0; k < nbytes; k++) begin
         byte_x(8'h00, rx);
         rxs[31 - 8*k -: 8] = rx;
      end
      ss_hi();
      chk("op_cmd_valid_count", 32'(cv_n - cv0), 1);
      chk("op_cmd", last_cmd, op);
      chk("op_cmd_unknown", last_unk, exp_unknown(op));
      chk("op_addr_kept", last_addr, a0);
      chk("op_oe_seen", oe_n != oe0, ID_EN && op == 8'h9F);
      chk("op_frame_done", 32'(fd_n - fd0), 1);
   endtask

   initial begin
      logic [31:0] rxs;
      logic [7:0] op, rx;
      int cv0, fd0, oe0, rr0;
      rst_n = 1'b0; ss = 1'b1; sclk = 1'b1; mosi = 1'b0;
      tick(3);
      chk("rst_miso", miso, 0);
      chk("rst_oe", miso_oe, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_unknown", cmd_unknown, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(10);
      chk("no_frame_done_after_reset", fd_n, 0);

      read_frame(8'h03, 24'h555555, 32'hA53C0000, 2);
      read_frame(8'h0B, 24'h555555, 32'h5A000000, 1);
      prog_frame(24'h000100, 32'hDEAD0000, 2, 0);
      prog_frame(24'h000100, 32'hDE000000, 1, 5);
      read_frame(8'h03, 24'h000100, 32'h12345678, 4);

      op_frame(8'h9F, 4, rxs);
`ifdef SPI_SLAVE_FL_READID_EN
      chk("readid_bytes", rxs, 32'h20BA1920);
`endif
      op_frame(8'h66, 0, rxs);
      op_frame(IGN[$urandom % 4], 1, rxs);
      for (int i = 0; i < 4; i++) begin
         op = 8'($urandom);
         while (op inside {8'h03, 8'h0B, 8'h02}) op = 8'($urandom);
         op_frame(op, 1, rxs);
      end

      for (int i = 0; i < 4; i++)
         read_frame(($urandom % 2) != 0 ? 8'h03 : 8'h0B, 24'($urandom), $urandom, 1 + int'($urandom % 4));
      for (int i = 0; i < 3; i++)
         prog_frame(24'($urandom), $urandom, int'($urandom % 4), int'($urandom % 8));

      cv0 = cv_n; fd0 = fd_n;
      ss_lo();
      ss_hi();
      chk("empty_frame_no_cmd", 32'(cv_n - cv0), 0);
      chk("empty_frame_done", 32'(fd_n - fd0), 1);

      cv0 = cv_n; oe0 = oe_n; rr0 = rr_n;
      ss_lo();
      byte_x(8'h03, rx);
      byte_x(8'h12, rx);
      rst_n = 1'b0;
      #1;
      chk("midrst_cmd", cmd, 0);
      chk("midrst_addr", addr, 0);
      chk("midrst_wr_data", wr_data, 0);
      chk("midrst_miso", miso, 0);
      chk("midrst_oe", miso_oe, 0);
      chk("midrst_busy", busy, 0);
      tick(2);
      rst_n = 1'b1;
      byte_x(8'h34, rx); byte_x(8'h56, rx); byte_x(8'h00, rx); byte_x(8'h00, rx);
      chk("midrst_ignored_busy", busy, 0);
      ss_hi();
      chk("midrst_no_cmd", 32'(cv_n - cv0), 0);
      chk("midrst_no_oe", 32'(oe_n - oe0), 0);
      chk("midrst_no_rd_req", 32'(rr_n - rr0), 0);
      read_frame(8'h03, 24'hABCDEF, 32'hC3000000, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_slave_fl.md
# spi_slave_fl

Single-lane SPI flash responder: the device end of the flash-master link. It sits behind the SPI pins of a test or emulation target, oversamples `sclk`/`ss`/`mosi_dq0` on the system clock, and decodes the flash frame: command, 24-bit address, dummy cycles, then data. It presents decoded commands and write bytes to a local controller and fetches read bytes from it to shift out on `miso_dq1`.

## Interface
- `CPOL`, default 1: sclk idle level.
- `CPHA`, default 1: 0 means sample on the leading edge; 1 means sample on the trailing edge. Shift happens on the opposite edge.
- `DUMMY_CYCLES`, default 8: dummy sclk cycles for FAST READ.
- `FLASH_ID`, default 24'h20BA19: READ ID response.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ss` in 1: chip select, active low.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `mosi_dq0` in 1: serial data from the master.
- `miso_dq1` out 1: serial data to the master.
- `miso_oe` out 1: output enable for `miso_dq1`.
- `cmd` out 8: last decoded command.
- `addr` out 24: last decoded start address.
- `cmd_valid` out 1: one-clk pulse when `cmd`/`addr` become valid.
- `cmd_unknown` out 1: qualifies `cmd_valid` for an unsupported opcode.
- `wr_data` out 8: received program byte.
- `wr_valid` out 1: one-clk pulse per complete program byte.
- `rd_req` out 1: one-clk pulse requesting the next read byte.
- `rd_data` in 8: read byte from the controller.
- `frame_done` out 1: one-clk pulse on `ss` deassertion.
- `busy` out 1: high while `ss` is asserted (synchronized).

## Operation
- **Input synchronization:** `sclk`, `ss` and `mosi_dq0` each pass through a 2-flop synchronizer. Edges are detected on the synchronized `sclk`. Sample and shift edges are derived from `CPOL`/`CPHA`.
- **Bit order:** all fields are MSB first. A bit counter tracks position within each field.
- **States:** IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE.
  - IDLE → CMD when synchronized `ss` falls.
  - CMD: 8 sample edges, then decode:
    - 0x03 READ → ADDR → DOUT.
    - 0x0B FAST READ → ADDR → DUMMY (`DUMMY_CYCLES` sample edges) → DOUT.
    - 0x02 PAGE PROGRAM → ADDR → DIN.
    - 0x9F READ ID → DOUT, streaming `FLASH_ID` bytes (see Configuration).
    - 0x06, 0x04, 0x66, 0x99 → IGNORE. These assert `cmd_valid` with `cmd_unknown`=0.
    - Any other opcode → IGNORE, asserting `cmd_valid` with `cmd_unknown`=1.
  - ADDR: 24 sample edges. For commands with an address, `cmd_valid` pulses the clk after the last address bit is sampled, with `addr` updated.
  - DOUT:
    - `miso_oe`=1; `miso_dq1` is updated on each shift edge.
    - `rd_req` pulses on the clk in which ADDR/DUMMY completes. It pulses again on the shift edge that drives bit 6 of each byte, prefetching the next byte.
    - The byte is loaded into the shift register at the first shift edge of each byte.
    - READ/FAST READ stream indefinitely. The controller owns address increment.
    - READ ID wraps to byte 0 after 3 bytes.
  - DIN: every 8th sample edge, `wr_data` is updated and `wr_valid` pulses the following clk.
  - IGNORE: all bits are discarded until `ss` deasserts.
- **`ss` deassertion:** synchronized `ss` rising in any state:
  - returns to IDLE;
  - drops `miso_oe` the same clk;
  - discards any partial byte (no `wr_valid`);
  - pulses `frame_done` once.
- **Missing sclk edges:** `ss` falling with no sclk edges followed by `ss` rising produces `frame_done` only.

## Timing
- `sclk` period ≥ 8 `clk` periods, and each `sclk` phase ≥ 4 `clk`. `ss` setup/hold to sclk ≥ 4 `clk`.
- Input-to-internal latency: 3 clk (2 sync + 1 edge detect).
- `rd_data` must be valid within 2 clk of `rd_req` and held until the next `rd_req`.
- **Reset values:**
  - `miso_dq1`=0, `miso_oe`=0, `cmd`=0, `addr`=0, `wr_data`=0;
  - all pulses 0, `busy`=0, state IDLE.
  - Reset asserted mid-frame aborts immediately. After release, the block waits for a fresh `ss` fall; a frame already in progress with `ss` low is ignored until `ss` rises.

## Configuration
- `SPI_SLAVE_FL_READID_EN` defined: 0x9F is supported as above.
- Undefined: the READ ID logic and `FLASH_ID` path are not compiled. 0x9F goes to IGNORE with `cmd_unknown`=1, and `miso_oe` stays 0.

## Test plan
- READ: `ss` low, send 0x03, 0x555555; controller answers `rd_req` with 0xA5 then 0x3C → `cmd_valid`, `cmd`=0x03, `addr`=0x555555; `miso_dq1` carries 0xA5, 0x3C MSB first; `frame_done` after `ss` high.
- FAST READ 0x0B, 0x555555 with 8 dummy cycles, `rd_data`=0x5A → `miso_oe` rises only after the 40th sample edge; master receives 0x5A.
- PAGE PROGRAM 0x02, 0x000100, bytes 0xDE, 0xAD → exactly two `wr_valid` pulses with 0xDE, 0xAD.
- `ss` raised after 5 bits of the second program byte → one `wr_valid` only, `frame_done`=1, `busy`=0, next frame decodes correctly.
- READ ID with macro → 0x20, 0xBA, 0x19, 0x20. Without macro → `cmd_unknown`=1, `miso_oe`=0. Opcode 0x66 → `cmd_valid` with `cmd_unknown`=0.
- `rst` low during ADDR phase → all outputs at reset values within 1 clk; the remainder of that frame is ignored.
